// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one external FP adder among NUM_REQ ports.
// Ports: req_* (valid/ready per requester), add_* (shared adder), resp_* (tagged result).
// Optional FP_ADD_ARB_STATS_EN macro adds stat_ops / stat_ovf counters.
module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_a,
  input  logic [32*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [31:0]            add_a,
  output logic [31:0]            add_b,
  input  logic [31:0]            add_result,
  input  logic                   add_overflow,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [31:0]            resp_result,
  output logic                   resp_overflow
`ifdef FP_ADD_ARB_STATS_EN
  ,
  output logic [15:0]            stat_ops,
  output logic [15:0]            stat_ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [31:0]       op_a_q, op_a_d;
  logic [31:0]       op_b_q, op_b_d;
  logic [ID_W-1:0]   op_id_q, op_id_d;
  logic [31:0]       resp_result_q, resp_result_d;
  logic              resp_overflow_q, resp_overflow_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic              resp_valid_q, resp_valid_d;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   cand;
  logic              grant;

  // Scan upward from the slot after the last grant, wrapping,
  // so the most recent winner has the lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_grant_q) + k) % NUM_REQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign grant = (state_q == IDLE) && win_found && !rst;

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    op_a_d          = op_a_q;
    op_b_d          = op_b_q;
    op_id_d         = op_id_q;
    resp_result_d   = resp_result_q;
    resp_overflow_d = resp_overflow_q;
    resp_id_d       = resp_id_q;
    resp_valid_d    = resp_valid_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          op_a_d       = req_a[32*win_idx +: 32];
          op_b_d       = req_b[32*win_idx +: 32];
          op_id_d      = win_idx;
          last_grant_d = win_idx;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        resp_result_d   = add_result;
        resp_overflow_d = add_overflow;
        resp_id_d       = op_id_q;
        resp_valid_d    = 1'b1;
        state_d         = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      last_grant_q    <= ID_W'(NUM_REQ - 1);
      op_a_q          <= '0;
      op_b_q          <= '0;
      op_id_q         <= '0;
      resp_result_q   <= '0;
      resp_overflow_q <= 1'b0;
      resp_id_q       <= '0;
      resp_valid_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      op_a_q          <= op_a_d;
      op_b_q          <= op_b_d;
      op_id_q         <= op_id_d;
      resp_result_q   <= resp_result_d;
      resp_overflow_q <= resp_overflow_d;
      resp_id_q       <= resp_id_d;
      resp_valid_q    <= resp_valid_d;
    end
  end

  assign add_a         = op_a_q;
  assign add_b         = op_b_q;
  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_result   = resp_result_q;
  assign resp_overflow = resp_overflow_q;

`ifdef FP_ADD_ARB_STATS_EN
  logic        hs;
  logic [15:0] stat_ops_q, stat_ops_d;
  logic [15:0] stat_ovf_q, stat_ovf_d;

  assign hs = resp_valid_q & resp_ready;

  // Counters stick at all-ones instead of wrapping.
  always_comb begin
    stat_ops_d = stat_ops_q;
    stat_ovf_d = stat_ovf_q;
    if (hs && stat_ops_q != 16'hFFFF) begin
      stat_ops_d = stat_ops_q + 16'd1;
    end
    if (hs && resp_overflow_q && stat_ovf_q != 16'hFFFF) begin
      stat_ovf_d = stat_ovf_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops_q <= '0;
      stat_ovf_q <= '0;
    end else begin
      stat_ops_q <= stat_ops_d;
      stat_ovf_q <= stat_ovf_d;
    end
  end

  assign stat_ops = stat_ops_q;
  assign stat_ovf = stat_ovf_q;
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a stub adder.
// Drives on negedge, samples 1ns later, well before the rising edge.
module tb_fp_add_arbiter;
  localparam int N = 4;
  localparam int W = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_a;
  logic [32*N-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic [31:0]     add_a, add_b;
  logic [31:0]     add_result;
  logic            add_overflow;
  logic            resp_valid;
  logic            resp_ready;
  logic [W-1:0]    resp_id;
  logic [31:0]     resp_result;
  logic            resp_overflow;
`ifdef FP_ADD_ARB_STATS_EN
  logic [15:0]     stat_ops, stat_ovf;
`endif

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fp_add_arbiter #(.NUM_REQ(N), .ID_W(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_ready    (req_ready),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_result   (add_result),
    .add_overflow (add_overflow),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_result  (resp_result),
    .resp_overflow(resp_overflow)
`ifdef FP_ADD_ARB_STATS_EN
    ,
    .stat_ops     (stat_ops),
    .stat_ovf     (stat_ovf)
`endif
  );

  // Stub adder: two known float pairs, otherwise a ^ b.
  always_comb begin
    add_result   = add_a ^ add_b;
    add_overflow = 1'b0;
    if (add_a == 32'h3F80_0000 && add_b == 32'h4000_0000) begin
      add_result = 32'h4040_0000;
    end else if (add_a == 32'h7F80_0000) begin
      add_result   = 32'h0;
      add_overflow = 1'b1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_op(input int i,
                        input logic [31:0] a,
                        input logic [31:0] b);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // One op from port i with resp_ready high; response checked at T+2.
  task automatic single(input string tag, input int i,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] er,
                        input logic eo);
    logic [N-1:0] oh;
    oh = '0;
    oh[i] = 1'b1;
    step();
    set_op(i, a, b);
    req_valid = oh;
    resp_ready = 1'b1;
    settle();
    chk({tag, "_grant"}, 32'(req_ready), 32'(oh));
    step();
    req_valid = '0;
    settle();
    chk({tag, "_exec_v"}, 32'(resp_valid), 32'd0);
    chk({tag, "_add_a"}, add_a, a);
    step();
    settle();
    chk({tag, "_v"}, 32'(resp_valid), 32'd1);
    chk({tag, "_id"}, 32'(resp_id), 32'(i));
    chk({tag, "_res"}, resp_result, er);
    chk({tag, "_ovf"}, 32'(resp_overflow), 32'(eo));
    step();
    settle();
    chk({tag, "_done"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b0;
    step();
    step();
    req_valid = '1;
    settle();
    chk("rst_rdy", 32'(req_ready), 32'd0);
    chk("rst_v", 32'(resp_valid), 32'd0);
    chk("rst_id", 32'(resp_id), 32'd0);
    chk("rst_res", resp_result, 32'd0);
    chk("rst_adda", add_a, 32'd0);
    req_valid = '0;
    step();
    rst = 1'b0;

    single("add", 2, 32'h3F80_0000, 32'h4000_0000,
           32'h4040_0000, 1'b0);
    single("ovf", 0, 32'h7F80_0000, 32'h3F80_0000,
           32'h0, 1'b1);
`ifdef FP_ADD_ARB_STATS_EN
    chk("st_ops", 32'(stat_ops), 32'd2);
    chk("st_ovf", 32'(stat_ovf), 32'd1);
`endif

    // Round-robin from reset, all ports valid.
    do_reset();
    for (int i = 0; i < N; i++) begin
      set_op(i, 32'h100 + 32'(i), 32'h200);
    end
    resp_ready = 1'b1;
    req_valid = '1;
    for (int g = 0; g < 5; g++) begin
      logic [N-1:0] oh;
      oh = '0;
      oh[g % N] = 1'b1;
      settle();
      chk($sformatf("rr_grant%0d", g), 32'(req_ready), 32'(oh));
      step();
      settle();
      chk($sformatf("rr_exec%0d", g), 32'(req_ready), 32'd0);
      step();
      settle();
      chk($sformatf("rr_v%0d", g), 32'(resp_valid), 32'd1);
      chk($sformatf("rr_id%0d", g), 32'(resp_id), 32'(g % N));
      chk($sformatf("rr_res%0d", g), resp_result,
          32'h300 + 32'(g % N));
      step();
    end
    req_valid = '0;
    resp_ready = 1'b0;
    step();
    step();
    step();
    resp_ready = 1'b1;
    step();
    step();
    // last grant is now port 0

    // Backpressure: port 1 wins over 3, then 3 waits behind the stall.
    resp_ready = 1'b0;
    set_op(1, 32'h55, 32'h0F);
    set_op(3, 32'hA0, 32'h0A);
    req_valid = 4'b1010;
    settle();
    chk("bp_grant1", 32'(req_ready), 32'b0010);
    step();
    req_valid = 4'b1000;
    step();
    for (int c = 0; c < 5; c++) begin
      settle();
      chk($sformatf("bp_v%0d", c), 32'(resp_valid), 32'd1);
      chk($sformatf("bp_id%0d", c), 32'(resp_id), 32'd1);
      chk($sformatf("bp_res%0d", c), resp_result, 32'h5A);
      chk($sformatf("bp_rdy%0d", c), 32'(req_ready), 32'd0);
      step();
    end
    resp_ready = 1'b1;
    settle();
    chk("bp_v_end", 32'(resp_valid), 32'd1);
    step();
    settle();
    chk("bp_grant3", 32'(req_ready), 32'b1000);
    step();
    req_valid = '0;
    step();
    settle();
    chk("bp_id3", 32'(resp_id), 32'd3);
    chk("bp_res3", resp_result, 32'hAA);
    step();

    // Fairness: 1 alone, then 0 and 1 -> 0 wins.
    single("fair1", 1, 32'h11, 32'h22, 32'h33, 1'b0);
    step();
    req_valid = 4'b0011;
    settle();
    chk("fair_grant0", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0010;
    step();
    step();
    settle();
    chk("fair_grant1", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    step();
    step();

    // Reset during EXEC drops the op.
    set_op(2, 32'h7F80_0000, 32'h1);
    req_valid = 4'b0100;
    settle();
    chk("mid_grant", 32'(req_ready), 32'b0100);
    step();
    req_valid = '0;
    rst = 1'b1;
    step();
    req_valid = 4'b0110;
    settle();
    chk("mid_v", 32'(resp_valid), 32'd0);
    chk("mid_rst_rdy", 32'(req_ready), 32'd0);
    rst = 1'b0;
    set_op(1, 32'hF0, 32'h0F);
    settle();
    chk("mid_first", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    settle();
    chk("mid_exec_v", 32'(resp_valid), 32'd0);
    step();
    settle();
    chk("mid_id", 32'(resp_id), 32'd1);
    chk("mid_res", resp_result, 32'hFF);
    chk("mid_ovf", 32'(resp_overflow), 32'd0);
`ifdef FP_ADD_ARB_STATS_EN
    chk("mid_st_ops", 32'(stat_ops), 32'd0);
`endif
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
